// File: rtl/ram_rmw_ctrl_if.sv
// ram_rmw_ctrl request/response handshake bundle.
// master = request source, slave = controller.
interface ram_rmw_ctrl_if #(
  parameter int ADDR_W = 36,
  parameter int DATA_W = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W/8-1:0]   req_be;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_be,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_be,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );
endinterface

// File: rtl/ram_rmw_ctrl.sv
// Byte-granular read-modify-write front end for the 64-bit main memory.
// Optional address range check: define RAM_RMW_RANGE_CHK_EN.
module ram_rmw_ctrl #(
  parameter int ADDR_W     = 36,
  parameter int DATA_W     = 64,
  parameter int MEM_DWORDS = 32768
) (
  input  logic              clock,
  input  logic              reset_n,
  ram_rmw_ctrl_if.slave     bus,
  output logic              mem_clock_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_enab,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int BE_W = DATA_W / 8;
  localparam int WA_W = ADDR_W - 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MRG,
    S_WR,
    S_RSP
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic              write_q;
  logic              write_d;
  logic [WA_W-1:0]   addr_q;
  logic [WA_W-1:0]   addr_d;
  logic [BE_W-1:0]   be_q;
  logic [BE_W-1:0]   be_d;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] buf_q;
  logic [DATA_W-1:0] buf_d;
  logic              err_q;
  logic              err_d;

  logic              accept;
  logic              oor;
  logic              be_full;
  logic              be_none;
  logic [DATA_W-1:0] merged;

  assign accept  = (state_q == S_IDLE) && bus.req_valid;
  assign be_full = &bus.req_be;
  assign be_none = ~|bus.req_be;

`ifdef RAM_RMW_RANGE_CHK_EN
  localparam logic [WA_W-1:0] DEPTH = WA_W'(MEM_DWORDS);
  assign oor = (bus.req_addr[ADDR_W-1:3] >= DEPTH);
`else
  assign oor = 1'b0;
`endif

  // Byte merge of latched write data over the word just read.
  always_comb begin
    merged = mem_data_out;
    for (int i = 0; i < BE_W; i++) begin
      if (be_q[i]) begin
        merged[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; request is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (oor) begin
            state_d = S_RSP;
          end else if (!bus.req_write) begin
            state_d = S_RD;
          end else if (be_full) begin
            state_d = S_WR;
          end else if (be_none) begin
            state_d = S_RSP;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:  state_d = S_MRG;
      S_MRG: state_d = write_q ? S_WR : S_RSP;
      S_WR:  state_d = S_RSP;
      S_RSP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch and word buffer next-state.
  always_comb begin
    write_d = write_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    err_d   = err_q;
    if (accept) begin
      write_d = bus.req_write;
      addr_d  = bus.req_addr[ADDR_W-1:3];
      be_d    = bus.req_be;
      wdata_d = bus.req_wdata;
      err_d   = oor;
      if (!oor && bus.req_write && be_full) begin
        buf_d = bus.req_wdata;
      end else begin
        buf_d = '0;
      end
    end else if (state_q == S_MRG) begin
      buf_d = write_q ? merged : mem_data_out;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      write_q <= write_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from state and latched registers only.
  always_comb begin
    bus.req_ready    = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_rdata    = '0;
    bus.rsp_err      = 1'b0;
    mem_clock_enable = 1'b0;
    mem_write_enab   = 1'b0;
    unique case (state_q)
      S_IDLE: bus.req_ready = 1'b1;
      S_RD:   mem_clock_enable = 1'b1;
      S_MRG:  ;
      S_WR: begin
        mem_clock_enable = 1'b1;
        mem_write_enab   = 1'b1;
      end
      S_RSP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = buf_q;
        bus.rsp_err   = err_q;
      end
      default: ;
    endcase
  end

  assign mem_addr    = {addr_q, 3'b000};
  assign mem_data_in = buf_q;

endmodule

// File: tb/tb_ram_rmw_ctrl.sv
// Directed bench for ram_rmw_ctrl with a clocked 1-port memory model.
// Build with RAM_RMW_RANGE_CHK_EN to exercise the range check.
module tb_ram_rmw_ctrl;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        mem_ce;
  logic        mem_we;
  logic [35:0] mem_addr;
  logic [63:0] mem_din;
  logic [63:0] mem_dout;
  logic [63:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  int          r_lat, r_ce, r_we, r_rd, r_rdy;
  logic [63:0] r_rdata;
  logic        r_err;
  logic [35:0] r_waddr, r_raddr;

  ram_rmw_ctrl_if bus ();

  ram_rmw_ctrl dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .bus              (bus),
    .mem_clock_enable (mem_ce),
    .mem_addr         (mem_addr),
    .mem_write_enab   (mem_we),
    .mem_data_in      (mem_din),
    .mem_data_out     (mem_dout)
  );

  always @(posedge clock) begin
    if (mem_ce) begin
      if (mem_we) mem[mem_addr[12:3]] <= mem_din;
      else        mem_dout <= mem[mem_addr[12:3]];
    end
  end

  task automatic do_req(input logic wr, input logic [35:0] a,
                        input logic [7:0] be, input logic [63:0] wd);
    int n;
    r_lat = -1; r_ce = 0; r_we = 0; r_rd = 0; r_rdy = 0;
    r_rdata = 'x; r_err = 1'bx; r_waddr = '0; r_raddr = '0;
    n = 0;
    @(negedge clock);
    while (!bus.req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_be    = be;
    bus.req_wdata = wd;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = ~wr;
    bus.req_addr  = 36'hF_FFFF_FFF8;
    bus.req_be    = 8'h5A;
    bus.req_wdata = '1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (mem_ce) r_ce++;
      if (mem_we) begin
        r_we++;
        r_waddr = mem_addr;
      end else if (mem_ce) begin
        r_rd++;
        r_raddr = mem_addr;
      end
      if (bus.req_ready) r_rdy++;
      if (bus.rsp_valid) begin
        r_lat   = k;
        r_rdata = bus.rsp_rdata;
        r_err   = bus.rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_be    = '0;
    bus.req_wdata = '0;
    #12;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_rsp: valid=%b err=%b rdata=%h want 0/0/0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    checks++;
    if (mem_ce !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 36'h0 || mem_din !== 64'h0) begin
      errors++;
      $display("FAIL reset_mem: ce=%b we=%b addr=%h din=%h want all 0",
               mem_ce, mem_we, mem_addr, mem_din);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_read();
    do_req(1'b0, 36'h08, 8'h00, 64'h0);
    checks++;
    if (r_lat !== 3) begin
      errors++;
      $display("FAIL read_lat: got %0d want 3", r_lat);
    end
    checks++;
    if (r_rdata !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL read_data: got %h want 1122334455667788", r_rdata);
    end
    checks++;
    if (r_we !== 0 || r_rd !== 1 || r_raddr !== 36'h08) begin
      errors++;
      $display("FAIL read_mem: we=%0d rd=%0d addr=%h want 0/1/008", r_we, r_rd, r_raddr);
    end
    checks++;
    if (r_rdy !== 0) begin
      errors++;
      $display("FAIL read_busy: ready seen %0d cycles want 0", r_rdy);
    end
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_ready_after: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_full_write();
    do_req(1'b1, 36'h10, 8'hFF, 64'hDEADBEEFCAFEF00D);
    checks++;
    if (r_lat !== 2 || r_rd !== 0 || r_we !== 1) begin
      errors++;
      $display("FAIL fw_timing: lat=%0d rd=%0d we=%0d want 2/0/1", r_lat, r_rd, r_we);
    end
    checks++;
    if (r_waddr !== 36'h10 || r_rdata !== 64'hDEADBEEFCAFEF00D) begin
      errors++;
      $display("FAIL fw_data: addr=%h rdata=%h want 010/deadbeefcafef00d", r_waddr, r_rdata);
    end
    do_req(1'b0, 36'h10, 8'h00, 64'h0);
    checks++;
    if (r_rdata !== 64'hDEADBEEFCAFEF00D) begin
      errors++;
      $display("FAIL fw_readback: got %h want deadbeefcafef00d", r_rdata);
    end
  endtask

  task automatic test_partial_write();
    do_req(1'b1, 36'h08, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
    checks++;
    if (r_lat !== 4 || r_we !== 1 || r_rd !== 1) begin
      errors++;
      $display("FAIL pw_timing: lat=%0d we=%0d rd=%0d want 4/1/1", r_lat, r_we, r_rd);
    end
    checks++;
    if (r_rdata !== 64'h11223344_BBBBBBBB) begin
      errors++;
      $display("FAIL pw_data: got %h want 11223344bbbbbbbb", r_rdata);
    end
    checks++;
    if (mem[1] !== 64'h11223344_BBBBBBBB) begin
      errors++;
      $display("FAIL pw_mem: got %h want 11223344bbbbbbbb", mem[1]);
    end
  endtask

  task automatic test_be_zero();
    do_req(1'b1, 36'h08, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++;
    if (r_lat !== 1 || r_ce !== 0 || r_rdata !== 64'h0) begin
      errors++;
      $display("FAIL be0: lat=%0d ce=%0d rdata=%h want 1/0/0", r_lat, r_ce, r_rdata);
    end
    checks++;
    if (mem[1] !== 64'h11223344_BBBBBBBB) begin
      errors++;
      $display("FAIL be0_mem: got %h want 11223344bbbbbbbb", mem[1]);
    end
  endtask

  task automatic test_back_to_back();
    do_req(1'b0, 36'h10, 8'h00, 64'h0);
    do_req(1'b0, 36'h08, 8'h00, 64'h0);
    checks++;
    if (r_lat !== 3 || r_rdata !== 64'h11223344_BBBBBBBB) begin
      errors++;
      $display("FAIL b2b: lat=%0d rdata=%h want 3/11223344bbbbbbbb", r_lat, r_rdata);
    end
  endtask

  task automatic test_reset_in_wr();
    int rsp_seen;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 36'h18;
    bus.req_be    = 8'hF0;
    bus.req_wdata = 64'hCCCCCCCC_CCCCCCCC;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_wr_enter: we=%b want 1", mem_we);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_ce !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_wr_drop: ce=%b we=%b want 0/0", mem_ce, mem_we);
    end
    @(negedge clock);
    reset_n = 1'b1;
    rsp_seen = 0;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_wr_ready: got %b want 1", bus.req_ready);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (bus.rsp_valid) rsp_seen++;
    end
    checks++;
    if (rsp_seen !== 0) begin
      errors++;
      $display("FAIL rst_wr_norsp: saw %0d responses want 0", rsp_seen);
    end
    checks++;
    if (mem[3] !== 64'h01234567_89ABCDEF) begin
      errors++;
      $display("FAIL rst_wr_mem: got %h want 0123456789abcdef", mem[3]);
    end
  endtask

  task automatic test_range();
    do_req(1'b0, 36'h4_0000, 8'h00, 64'h0);
`ifdef RAM_RMW_RANGE_CHK_EN
    checks++;
    if (r_lat !== 1 || r_err !== 1'b1 || r_rdata !== 64'h0 || r_ce !== 0) begin
      errors++;
      $display("FAIL range_rej: lat=%0d err=%b rdata=%h ce=%0d want 1/1/0/0",
               r_lat, r_err, r_rdata, r_ce);
    end
`else
    checks++;
    if (r_lat !== 3 || r_err !== 1'b0 || r_raddr !== 36'h4_0000) begin
      errors++;
      $display("FAIL range_pass: lat=%0d err=%b addr=%h want 3/0/040000",
               r_lat, r_err, r_raddr);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 64'h0;
    mem[1] = 64'h1122334455667788;
    mem[3] = 64'h0123456789ABCDEF;
    test_reset();
    test_read();
    test_full_write();
    test_partial_write();
    test_be_zero();
    test_back_to_back();
    test_reset_in_wr();
    test_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
endmodule
